uart_rx_cmd_ctrl: RTL and testbench

Command-frame controller that sits behind the UART receiver. It consumes received bytes (parallel data, data_valid, parity_error, framing_error) and decodes write/read command frames. It sequences register-file write and read accesses, and hands read-back data to the UART transmitter. Frames that are malformed, corrupted or stalled are aborted and reported, so the register file only ever sees complete, error-free commands.

---
 rtl/uart_rx_cmd_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_cmd_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_ctrl.sv
// rtl/uart_rx_cmd_ctrl.sv - UART command-frame decoder driving register-file writes/reads and TX read-back
module uart_rx_cmd_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int TIMEOUT_CYC   = 4096,
    parameter int TIMEOUT_WIDTH = 13
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_PAR_ERR,
    input  logic                  RX_FRM_ERR,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    input  logic [DATA_WIDTH-1:0] RF_RdData,
    input  logic                  RF_RdData_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_Busy,
    output logic                  cmd_error,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_e;

    localparam logic [7:0]               OP_WRITE = 8'hAA;
    localparam logic [7:0]               OP_READ  = 8'hBB;
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYC - 1);

    state_e                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     rf_wr_en_q, rf_wr_en_d;
    logic                     rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_WIDTH-1:0]    rf_address_q, rf_address_d;
    logic [DATA_WIDTH-1:0]    rf_wr_data_q, rf_wr_data_d;
    logic [DATA_WIDTH-1:0]    tx_p_data_q, tx_p_data_d;
    logic                     tx_d_vld_q, tx_d_vld_d;
    logic                     cmd_error_q, cmd_error_d;
    logic                     busy_q, busy_d;

    logic good_byte;
    logic addr_ok;
    logic is_write_op;
    logic is_read_op;
    logic waiting;
    logic timeout;

    assign good_byte   = RX_D_VLD && !RX_PAR_ERR && !RX_FRM_ERR;
    assign addr_ok     = ((RX_P_DATA >> ADDR_WIDTH) == '0);
    assign is_write_op = (RX_P_DATA[7:0] == OP_WRITE);
    assign is_read_op  = (RX_P_DATA[7:0] == OP_READ);
    assign waiting     = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                         (state_q == RD_ADDR) || (state_q == RD_WAIT);
    // Fires on the cycle the count would reach TIMEOUT_CYC; the abort shows one cycle later.
    assign timeout     = waiting && (cnt_q == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_address_q <= '0;
            rf_wr_data_q <= '0;
            tx_p_data_q  <= '0;
            tx_d_vld_q   <= 1'b0;
            cmd_error_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_address_q <= rf_address_d;
            rf_wr_data_q <= rf_wr_data_d;
            tx_p_data_q  <= tx_p_data_d;
            tx_d_vld_q   <= tx_d_vld_d;
            cmd_error_q  <= cmd_error_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (good_byte && is_write_op) begin
                    state_d = WR_ADDR;
                end else if (good_byte && is_read_op) begin
                    state_d = RD_ADDR;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    state_d = (good_byte && addr_ok) ? WR_DATA : IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD || timeout) begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    state_d = (good_byte && addr_ok) ? RD_WAIT : IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (RF_RdData_VLD) begin
                    state_d = TX_SEND;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            TX_SEND: begin
                if (!TX_Busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every accepted byte moves the FSM, so a state change is the only clear condition needed.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        end
    end

    always_comb begin
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        tx_d_vld_d   = 1'b0;
        cmd_error_d  = 1'b0;
        rf_address_d = rf_address_q;
        rf_wr_data_d = rf_wr_data_q;
        tx_p_data_d  = tx_p_data_q;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                cmd_error_d = RX_D_VLD && !(good_byte && (is_write_op || is_read_op));
            end
            WR_ADDR, RD_ADDR: begin
                if (good_byte && addr_ok) begin
                    rf_address_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    rf_rd_en_d   = (state_q == RD_ADDR);
                end else if (RX_D_VLD || timeout) begin
                    cmd_error_d = 1'b1;
                end
            end
            WR_DATA: begin
                if (good_byte) begin
                    rf_wr_data_d = RX_P_DATA;
                    rf_wr_en_d   = 1'b1;
                end else if (RX_D_VLD || timeout) begin
                    cmd_error_d = 1'b1;
                end
            end
            RD_WAIT: begin
                if (RF_RdData_VLD) begin
                    tx_p_data_d = RF_RdData;
                end
                // A read response arriving on the timeout cycle still wins.
                cmd_error_d = RX_D_VLD || (timeout && !RF_RdData_VLD);
            end
            TX_SEND: begin
                tx_d_vld_d  = !TX_Busy;
                cmd_error_d = RX_D_VLD;
            end
            default: begin
                cmd_error_d = 1'b0;
            end
        endcase
    end

    assign RF_WrEn    = rf_wr_en_q;
    assign RF_RdEn    = rf_rd_en_q;
    assign RF_Address = rf_address_q;
    assign RF_WrData  = rf_wr_data_q;
    assign TX_P_DATA  = tx_p_data_q;
    assign TX_D_VLD   = tx_d_vld_q;
    assign cmd_error  = cmd_error_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// tb/tb_uart_rx_cmd_ctrl.sv - scoreboard bench for uart_rx_cmd_ctrl with a 16-cycle timeout
module tb_uart_rx_cmd_ctrl;

    localparam int EV_WR  = 0;
    localparam int EV_RD  = 1;
    localparam int EV_TX  = 2;
    localparam int EV_ERR = 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic       RX_PAR_ERR;
    logic       RX_FRM_ERR;
    logic       RF_WrEn;
    logic       RF_RdEn;
    logic [3:0] RF_Address;
    logic [7:0] RF_WrData;
    logic [7:0] RF_RdData;
    logic       RF_RdData_VLD;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       TX_Busy;
    logic       cmd_error;
    logic       busy;

    typedef struct {
        int          kind;
        logic [31:0] val;
        int          cyc;
    } ev_t;

    ev_t sb[$];
    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    uart_rx_cmd_ctrl #(
        .DATA_WIDTH   (8),
        .ADDR_WIDTH   (4),
        .TIMEOUT_CYC  (16),
        .TIMEOUT_WIDTH(5)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .RX_PAR_ERR   (RX_PAR_ERR),
        .RX_FRM_ERR   (RX_FRM_ERR),
        .RF_WrEn      (RF_WrEn),
        .RF_RdEn      (RF_RdEn),
        .RF_Address   (RF_Address),
        .RF_WrData    (RF_WrData),
        .RF_RdData    (RF_RdData),
        .RF_RdData_VLD(RF_RdData_VLD),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .TX_Busy      (TX_Busy),
        .cmd_error    (cmd_error),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] val, input int at);
        sb.push_back('{kind, val, at});
    endtask

    task automatic check_evt(input int kind, input logic [31:0] val);
        ev_t e;
        n_tests++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected: observed event %0d val %0h at cycle %0d expected none", kind, val, cyc);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_value", val, e.val);
            chk("sb_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (RF_WrEn)   check_evt(EV_WR, {20'd0, RF_Address, RF_WrData});
        if (RF_RdEn)   check_evt(EV_RD, {28'd0, RF_Address});
        if (TX_D_VLD)  check_evt(EV_TX, {24'd0, TX_P_DATA});
        if (cmd_error) check_evt(EV_ERR, 32'd0);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic fe);
        RX_P_DATA  = d;
        RX_PAR_ERR = pe;
        RX_FRM_ERR = fe;
        RX_D_VLD   = 1'b1;
        tick();
        RX_D_VLD   = 1'b0;
        RX_PAR_ERR = 1'b0;
        RX_FRM_ERR = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wren"}, RF_WrEn, 0);
        chk({tag, "_rden"}, RF_RdEn, 0);
        chk({tag, "_addr"}, RF_Address, 0);
        chk({tag, "_wrdata"}, RF_WrData, 0);
        chk({tag, "_txdata"}, TX_P_DATA, 0);
        chk({tag, "_txvld"}, TX_D_VLD, 0);
        chk({tag, "_err"}, cmd_error, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        RX_P_DATA = '0; RX_D_VLD = 1'b0; RX_PAR_ERR = 1'b0; RX_FRM_ERR = 1'b0;
        RF_RdData = '0; RF_RdData_VLD = 1'b0; TX_Busy = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        RST = 1'b0;
        tick();

        // Write frame, bytes 12 cycles apart (inside the 16-cycle timeout)
        send(8'hAA, 0, 0);
        chk("wr_busy_high", busy, 1);
        repeat (11) tick();
        send(8'h05, 0, 0);
        repeat (11) tick();
        push(EV_WR, 32'h053C, cyc + 1);
        send(8'h3C, 0, 0);
        chk("wr_busy_low", busy, 0);
        chk("wr_addr", RF_Address, 5);
        repeat (3) tick();

        // Read, TX idle, RF answers 3 cycles after RF_RdEn
        push(EV_RD, 2, cyc + 2);
        send(8'hBB, 0, 0);
        send(8'h02, 0, 0);
        repeat (3) tick();
        push(EV_TX, 8'h77, cyc + 2);
        RF_RdData = 8'h77; RF_RdData_VLD = 1'b1;
        tick();
        RF_RdData_VLD = 1'b0;
        chk("rd_txdata", TX_P_DATA, 8'h77);
        chk("rd_busy_high", busy, 1);
        tick();
        chk("rd_busy_low", busy, 0);
        repeat (3) tick();

        // Read with TX busy; response in the RF_RdEn cycle; RX bytes dropped during the hold
        TX_Busy = 1'b1;
        push(EV_RD, 3, cyc + 2);
        send(8'hBB, 0, 0);
        send(8'h03, 0, 0);
        RF_RdData = 8'hC5; RF_RdData_VLD = 1'b1;
        tick();
        RF_RdData_VLD = 1'b0;
        chk("hold_txdata", TX_P_DATA, 8'hC5);
        repeat (10) tick();
        push(EV_ERR, 0, cyc + 1);
        send(8'h11, 0, 0);
        repeat (10) tick();
        push(EV_ERR, 0, cyc + 1);
        send(8'h22, 0, 1);
        repeat (28) tick();
        chk("hold_txdata_kept", TX_P_DATA, 8'hC5);
        chk("hold_busy", busy, 1);
        TX_Busy = 1'b0;
        push(EV_TX, 8'hC5, cyc + 1);
        tick();
        chk("hold_busy_low", busy, 0);
        repeat (3) tick();

        // Bad opcode
        push(EV_ERR, 0, cyc + 1);
        send(8'h55, 0, 0);
        chk("badop_busy", busy, 0);
        repeat (2) tick();

        // Illegal address
        send(8'hAA, 0, 0);
        push(EV_ERR, 0, cyc + 1);
        send(8'h12, 0, 0);
        chk("badaddr_busy", busy, 0);
        repeat (2) tick();

        // Parity error on the data byte
        send(8'hAA, 0, 0);
        send(8'h01, 0, 0);
        push(EV_ERR, 0, cyc + 1);
        send(8'h3C, 1, 0);
        chk("parerr_busy", busy, 0);
        repeat (2) tick();

        // Write opcode then silence
        push(EV_ERR, 0, cyc + 17);
        send(8'hAA, 0, 0);
        repeat (20) tick();
        chk("wr_to_busy", busy, 0);

        // Read with no RF response
        push(EV_RD, 4, cyc + 2);
        push(EV_ERR, 0, cyc + 18);
        send(8'hBB, 0, 0);
        send(8'h04, 0, 0);
        repeat (20) tick();
        chk("rd_to_busy", busy, 0);

        // Response on the timeout cycle wins
        push(EV_RD, 6, cyc + 2);
        send(8'hBB, 0, 0);
        send(8'h06, 0, 0);
        repeat (15) tick();
        push(EV_TX, 8'h5A, cyc + 2);
        RF_RdData = 8'h5A; RF_RdData_VLD = 1'b1;
        tick();
        RF_RdData_VLD = 1'b0;
        repeat (4) tick();

        // Dropped byte together with the read response
        push(EV_RD, 7, cyc + 2);
        send(8'hBB, 0, 0);
        send(8'h07, 0, 0);
        push(EV_ERR, 0, cyc + 1);
        push(EV_TX, 8'h81, cyc + 2);
        RF_RdData = 8'h81; RF_RdData_VLD = 1'b1;
        RX_P_DATA = 8'h44; RX_D_VLD = 1'b1;
        tick();
        RF_RdData_VLD = 1'b0; RX_D_VLD = 1'b0;
        repeat (4) tick();

        // Reset mid-frame, then a non-opcode byte
        send(8'hAA, 0, 0);
        send(8'h03, 0, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_all_zero("midrst");
        push(EV_ERR, 0, cyc + 1);
        send(8'h99, 0, 0);
        repeat (5) tick();

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
